// File: rtl/sm_divider.sv
// Iterative restoring divider on N-bit sign-magnitude words, one quotient bit per cycle.
// Valid/ready on both sides; the result is held in DONE until out_ready.
module sm_divider #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] q,
   output logic [N-1:0] r,
   output logic         div_by_zero
);

   localparam int M  = N - 1;
   localparam int CW = $clog2(M);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state;
   logic [M-1:0]  dvd;
   logic [M-1:0]  dvs;
   logic [M-1:0]  quo;
   logic [M-1:0]  rem;
   logic [CW-1:0] cnt;
   logic          sign_q;
   logic          sign_r;
   logic          dbz;

   logic [N-1:0]  p_shift;
   logic [M-1:0]  p_diff;
   logic          take;

   // The remainder is always below |b|, so its top bit lives only in p_shift.
   always_comb begin
      p_shift = {rem, dvd[M-1]};
      take    = (p_shift >= {1'b0, dvs});
      p_diff  = p_shift[M-1:0] - dvs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
         dvd         <= '0;
         dvs         <= '0;
         quo         <= '0;
         rem         <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dbz         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  dvd      <= a[M-1:0];
                  dvs      <= b[M-1:0];
                  sign_q   <= a[N-1] ^ b[N-1];
                  sign_r   <= a[N-1];
                  rem      <= '0;
                  quo      <= '0;
                  cnt      <= '0;
                  dbz      <= (b[M-1:0] == '0);
                  state    <= (b[M-1:0] == '0) ? DONE : CALC;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CALC: begin
               rem <= take ? p_diff : p_shift[M-1:0];
               dvd <= {dvd[M-2:0], 1'b0};
               quo <= {quo[M-2:0], take};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N - 2))
                  state <= DONE;
            end
            DONE: begin
               // First DONE cycle formats the result; later cycles wait for the consumer.
               if (!out_valid) begin
                  out_valid   <= 1'b1;
                  div_by_zero <= dbz;
                  if (dbz) begin
                     q <= {sign_q, {M{1'b1}}};
                     r <= (dvd == '0) ? '0 : {sign_r, dvd};
                  end else begin
                     q <= {sign_q & (|quo), quo};
                     r <= {sign_r & (|rem), rem};
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
